// File: rtl/dmem_ctrl.sv
// Data-memory controller: posts stores into a small buffer, drains it to a
// req/ack SRAM port, and runs loads after the buffer is empty so that a load
// never reads data older than a store issued before it.
module dmem_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               proc2Dmem_command,
  input  logic [31:0]              proc2Dmem_addr,
  input  logic [31:0]              proc2Dmem_data,
  input  logic [2:0]               proc2Dmem_funct3,
  output logic [31:0]              Dmem2proc_data,
  output logic                     dmem_stall,
  output logic                     access_err,
  output logic [$clog2(DEPTH):0]   sb_count,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [31:0]              mem_addr,
  output logic [31:0]              mem_wdata,
  output logic [3:0]               mem_be,
  input  logic                     mem_ack,
  input  logic [31:0]              mem_rdata
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, LD_DRAIN, LD_REQ, LD_DONE} state_t;

  state_t state, next_state;

  logic [29:0]   sb_addr [DEPTH];
  logic [3:0]    sb_be   [DEPTH];
  logic [31:0]   sb_data [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  logic        is_load, is_store, f3_legal, misaligned, dec_err;
  logic        fifo_empty, fifo_full, push, pop;
  logic [3:0]  st_be;
  logic [31:0] st_data;
  logic [31:0] rdata_q;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CW'(DEPTH));
  assign sb_count   = count;

  // Decode the command: legality of the size code, alignment, and lane placement for stores
  always_comb begin
    is_load  = (proc2Dmem_command == 2'd1);
    is_store = (proc2Dmem_command == 2'd2);
    case (proc2Dmem_funct3)
      3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
      3'b100, 3'b101:         f3_legal = is_load;
      default:                f3_legal = 1'b0;
    endcase
    misaligned = ((proc2Dmem_funct3[1:0] == 2'b01) && proc2Dmem_addr[0]) ||
                 ((proc2Dmem_funct3[1:0] == 2'b10) && (proc2Dmem_addr[1:0] != 2'b00));
    dec_err    = (is_load || is_store) && (!f3_legal || misaligned);
    st_be      = 4'b1111;
    st_data    = proc2Dmem_data;
    case (proc2Dmem_funct3[1:0])
      2'b00: begin
        st_be   = 4'b0001 << proc2Dmem_addr[1:0];
        st_data = {4{proc2Dmem_data[7:0]}};
      end
      2'b01: begin
        st_be   = proc2Dmem_addr[1] ? 4'b1100 : 4'b0011;
        st_data = {2{proc2Dmem_data[15:0]}};
      end
      default: begin
        st_be   = 4'b1111;
        st_data = proc2Dmem_data;
      end
    endcase
  end

  // Stores are accepted only while the load FSM is idle; the head pops when its write is acked
  assign push = (state == IDLE) && is_store && !dec_err && !fifo_full;
  assign pop  = mem_ack && !fifo_empty;

  // Store-buffer pointers and occupancy; reset discards any buffered stores
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Store-buffer payload; contents need no reset because the pointers gate them
  always_ff @(posedge clk) begin
    if (push) begin
      sb_addr[wr_ptr] <= proc2Dmem_addr[31:2];
      sb_be[wr_ptr]   <= st_be;
      sb_data[wr_ptr] <= st_data;
    end
  end

  // Load FSM state and captured read word
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      rdata_q <= '0;
    end else begin
      state <= next_state;
      if (state == LD_REQ && mem_ack) rdata_q <= mem_rdata;
    end
  end

  // Load FSM sequencing and processor-facing handshake
  always_comb begin
    next_state = state;
    dmem_stall = 1'b0;
    access_err = 1'b0;
    case (state)
      IDLE: begin
        access_err = dec_err;
        dmem_stall = !dec_err && (is_load || (is_store && fifo_full));
        if (is_load && !dec_err) next_state = fifo_empty ? LD_REQ : LD_DRAIN;
      end
      LD_DRAIN: begin
        dmem_stall = 1'b1;
        if (fifo_empty || (count == CW'(1) && mem_ack)) next_state = LD_REQ;
      end
      LD_REQ: begin
        dmem_stall = 1'b1;
        if (mem_ack) next_state = LD_DONE;
      end
      LD_DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // SRAM port: the buffer head is written whenever present, otherwise the pending load reads
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if (!fifo_empty) begin
      mem_req   = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = {sb_addr[rd_ptr], 2'b00};
      mem_wdata = sb_data[rd_ptr];
      mem_be    = sb_be[rd_ptr];
    end else if (state == LD_REQ) begin
      mem_req  = 1'b1;
      mem_addr = {proc2Dmem_addr[31:2], 2'b00};
      mem_be   = 4'b1111;
    end
  end

  // Lane extraction and sign/zero extension of the returned word
  always_comb begin
    case (proc2Dmem_addr[1:0])
      2'b00:   ld_byte = rdata_q[7:0];
      2'b01:   ld_byte = rdata_q[15:8];
      2'b10:   ld_byte = rdata_q[23:16];
      default: ld_byte = rdata_q[31:24];
    endcase
    ld_half        = proc2Dmem_addr[1] ? rdata_q[31:16] : rdata_q[15:0];
    Dmem2proc_data = '0;
    if (state == LD_DONE) begin
      case (proc2Dmem_funct3)
        3'b000:  Dmem2proc_data = {{24{ld_byte[7]}}, ld_byte};
        3'b100:  Dmem2proc_data = {24'h0, ld_byte};
        3'b001:  Dmem2proc_data = {{16{ld_half[15]}}, ld_half};
        3'b101:  Dmem2proc_data = {16'h0, ld_half};
        3'b010:  Dmem2proc_data = rdata_q;
        default: Dmem2proc_data = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: stimulus pushes expected SRAM writes, reads
// and load results into queues; a monitor pops and compares them as the DUT
// presents each handshake.
module tb_dmem_ctrl;

  localparam logic [1:0] BUS_NONE  = 2'd0;
  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  cmd = BUS_NONE;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [2:0]  f3 = '0;
  logic [31:0] Dmem2proc_data;
  logic        dmem_stall;
  logic        access_err;
  logic [2:0]  sb_count;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  logic        ack_en = 1'b1;
  int          tests = 0;
  int          fails = 0;

  wr_t         exp_wr[$];
  logic [31:0] exp_rd[$];
  logic [31:0] exp_ld[$];
  bit   [31:0] sram [bit [29:0]];

  dmem_ctrl #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .proc2Dmem_command(cmd), .proc2Dmem_addr(addr),
    .proc2Dmem_data(wdata), .proc2Dmem_funct3(f3),
    .Dmem2proc_data(Dmem2proc_data), .dmem_stall(dmem_stall),
    .access_err(access_err), .sb_count(sb_count),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // SRAM responder and scoreboard monitor
  always @(negedge clk) begin
    mem_ack   = mem_req && ack_en;
    mem_rdata = (mem_req && !mem_we && sram.exists(mem_addr[31:2])) ? sram[mem_addr[31:2]] : 32'h0;
    #1;
    if (rst && mem_req && mem_ack) begin
      if (mem_we) begin
        if (exp_wr.size() == 0) begin
          tests++; fails++;
          $display("[TB] FAIL unexpected_write: got addr %h data %h, expected none", mem_addr, mem_wdata);
        end else begin
          wr_t w;
          bit [31:0] old;
          w = exp_wr.pop_front();
          checkOutput("wr_addr", mem_addr, w.addr);
          checkOutput("wr_be", {28'h0, mem_be}, {28'h0, w.be});
          checkOutput("wr_data", mem_wdata, w.data);
          old = sram.exists(mem_addr[31:2]) ? sram[mem_addr[31:2]] : 32'h0;
          for (int b = 0; b < 4; b++)
            if (mem_be[b]) old[b*8 +: 8] = mem_wdata[b*8 +: 8];
          sram[mem_addr[31:2]] = old;
        end
      end else begin
        if (exp_rd.size() == 0) begin
          tests++; fails++;
          $display("[TB] FAIL unexpected_read: got addr %h, expected none", mem_addr);
        end else begin
          checkOutput("rd_addr", mem_addr, exp_rd.pop_front());
          checkOutput("rd_be", {28'h0, mem_be}, 32'hF);
        end
      end
    end
    if (rst && cmd == BUS_LOAD && !dmem_stall && !access_err) begin
      if (exp_ld.size() == 0) begin
        tests++; fails++;
        $display("[TB] FAIL unexpected_load: got %h, expected none", Dmem2proc_data);
      end else begin
        checkOutput("load_data", Dmem2proc_data, exp_ld.pop_front());
      end
    end
  end

  // Present one command (called at posedge+2), hold it while stalled, return stalled cycles
  task automatic applyStimulus(input logic [1:0] c, input logic [31:0] a, input logic [31:0] d,
                               input logic [2:0] f, output int stalled);
    cmd = c; addr = a; wdata = d; f3 = f;
    stalled = 0;
    forever begin
      @(negedge clk); #3;
      if (!dmem_stall) break;
      stalled++;
      if (stalled > 100) begin
        tests++; fails++;
        $display("[TB] FAIL stall_timeout: got stall after %0d cycles, expected release", stalled);
        break;
      end
      @(posedge clk); #2;
    end
    @(posedge clk); #2;
    cmd = BUS_NONE;
  endtask

  task automatic waitDrain();
    int n = 0;
    while ((sb_count != 0 || mem_req) && n < 100) begin
      @(posedge clk); #2;
      n++;
    end
    checkOutput("drain_done", {31'h0, (n < 100)}, 32'h1);
  endtask

  task automatic checkError(input logic [1:0] c, input logic [31:0] a, input logic [2:0] f, input string name);
    cmd = c; addr = a; wdata = 32'h12345678; f3 = f;
    @(negedge clk); #3;
    checkOutput({name, "_err"}, {31'h0, access_err}, 32'h1);
    checkOutput({name, "_stall"}, {31'h0, dmem_stall}, 32'h0);
    checkOutput({name, "_req"}, {31'h0, mem_req}, 32'h0);
    checkOutput({name, "_data"}, Dmem2proc_data, 32'h0);
    @(posedge clk); #2;
    cmd = BUS_NONE;
    checkOutput({name, "_sbcount"}, {29'h0, sb_count}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int st;
    // Reset state
    #12;
    checkOutput("rst_req", {31'h0, mem_req}, 32'h0);
    checkOutput("rst_sbcount", {29'h0, sb_count}, 32'h0);
    checkOutput("rst_stall", {31'h0, dmem_stall}, 32'h0);
    checkOutput("rst_outs", mem_addr | mem_wdata | Dmem2proc_data | {27'h0, mem_we, mem_be}, 32'h0);
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #2;
    checkOutput("post_rst_req", {31'h0, mem_req}, 32'h0);
    checkOutput("post_rst_err", {31'h0, access_err}, 32'h0);

    // Single word store
    exp_wr.push_back('{32'h100, 4'hF, 32'hDEADBEEF});
    applyStimulus(BUS_STORE, 32'h100, 32'hDEADBEEF, 3'b010, st);
    checkOutput("sw_stall", st, 0);
    checkOutput("sw_sbcount1", {29'h0, sb_count}, 32'h1);
    waitDrain();
    checkOutput("sw_sbcount0", {29'h0, sb_count}, 32'h0);

    // Fill the buffer with acks held off, then overflow by one
    ack_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_wr.push_back('{32'h300, 4'b0001 << i, {4{8'(8'h11 * (i + 1))}}});
      applyStimulus(BUS_STORE, 32'h300 + i, 32'(8'h11 * (i + 1)), 3'b000, st);
      checkOutput("sb_fill_stall", st, 0);
    end
    checkOutput("sb_full_count", {29'h0, sb_count}, 32'h4);
    exp_wr.push_back('{32'h304, 4'b0001, 32'h55555555});
    fork
      begin
        repeat (3) @(posedge clk);
        ack_en = 1'b1;
      end
    join_none
    applyStimulus(BUS_STORE, 32'h304, 32'h00000055, 3'b000, st);
    checkOutput("sb_overflow_stalled", {31'h0, (st >= 3)}, 32'h1);
    waitDrain();
    checkOutput("sb_writes_all_seen", exp_wr.size(), 0);

    // Store then loads of each size/sign
    exp_wr.push_back('{32'h200, 4'hF, 32'h80FF7F01});
    applyStimulus(BUS_STORE, 32'h200, 32'h80FF7F01, 3'b010, st);
    exp_rd.push_back(32'h200); exp_ld.push_back(32'hFFFFFF80);
    applyStimulus(BUS_LOAD, 32'h203, 32'h0, 3'b000, st);
    checkOutput("lb_after_store_stalled", {31'h0, (st >= 3)}, 32'h1);
    exp_rd.push_back(32'h200); exp_ld.push_back(32'h00000080);
    applyStimulus(BUS_LOAD, 32'h203, 32'h0, 3'b100, st);
    exp_rd.push_back(32'h200); exp_ld.push_back(32'hFFFF80FF);
    applyStimulus(BUS_LOAD, 32'h202, 32'h0, 3'b001, st);
    exp_rd.push_back(32'h200); exp_ld.push_back(32'h00007F01);
    applyStimulus(BUS_LOAD, 32'h200, 32'h0, 3'b101, st);
    checkOutput("load_latency", st, 2);

    // Decode errors
    checkError(BUS_LOAD, 32'h102, 3'b010, "lw_misaligned");
    checkError(BUS_STORE, 32'h101, 3'b001, "sh_misaligned");
    checkError(BUS_LOAD, 32'h100, 3'b011, "illegal_f3");
    checkError(BUS_STORE, 32'h100, 3'b100, "store_bu");

    // Reset in the middle of a load request
    ack_en = 1'b0;
    cmd = BUS_LOAD; addr = 32'h200; f3 = 3'b010;
    @(posedge clk); #2;
    checkOutput("ldreq_req", {31'h0, mem_req}, 32'h1);
    cmd = BUS_NONE;
    rst = 1'b0;
    #1;
    checkOutput("async_rst_req", {31'h0, mem_req}, 32'h0);
    @(posedge clk); #2;
    @(posedge clk); #2;
    rst = 1'b1;
    ack_en = 1'b1;
    @(posedge clk); #2;
    checkOutput("after_rst_sbcount", {29'h0, sb_count}, 32'h0);
    checkOutput("after_rst_stall", {31'h0, dmem_stall}, 32'h0);
    exp_rd.push_back(32'h200); exp_ld.push_back(32'h80FF7F01);
    applyStimulus(BUS_LOAD, 32'h200, 32'h0, 3'b010, st);
    checkOutput("after_rst_latency", st, 2);

    repeat (3) @(posedge clk);
    checkOutput("wr_queue_empty", exp_wr.size(), 0);
    checkOutput("rd_queue_empty", exp_rd.size(), 0);
    checkOutput("ld_queue_empty", exp_ld.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
